// File: rtl/irq_event_arbiter.sv
// Rising-edge capture of interrupt lines into a pending register, with round-robin
// selection of one eligible line per cycle pushed as an ID into the downstream FIFO.
module irq_event_arbiter #(
  parameter int unsigned NUM_IRQ  = 32,
  parameter int unsigned ID_WIDTH = $clog2(NUM_IRQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  mask_i,
  input  logic [NUM_IRQ-1:0]  ovf_clr_i,
  input  logic                fifo_full_i,
  output logic                push_o,
  output logic [ID_WIDTH-1:0] data_o,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic [NUM_IRQ-1:0]  overflow_o
);

  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pending_q;
  logic [NUM_IRQ-1:0]  overflow_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] rr_ptr_d;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  elig;
  logic [NUM_IRQ-1:0]  below_ptr;
  logic [NUM_IRQ-1:0]  elig_hi;
  logic [NUM_IRQ-1:0]  cand;
  logic [NUM_IRQ-1:0]  grant;
  logic [ID_WIDTH-1:0] sel;
  logic                push;

  assign rise = irq_i & ~irq_q & mask_i;
  assign elig = pending_q & mask_i;

  // Lines at or above the pointer win; otherwise wrap and take the lowest eligible line.
  assign below_ptr = (NUM_IRQ'(1) << rr_ptr_q) - NUM_IRQ'(1);
  assign elig_hi   = elig & ~below_ptr;
  assign cand      = (|elig_hi) ? elig_hi : elig;

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel = ID_WIDTH'(i);
      end
    end
  end

  assign push  = (|elig) & ~fifo_full_i & ~flush_i & ~rst_i;
  assign grant = push ? (NUM_IRQ'(1) << sel) : '0;

  // Explicit wrap so non-power-of-two line counts never point past the last line.
  assign rr_ptr_d = (32'(sel) == NUM_IRQ - 1) ? '0 : sel + 1'b1;

  always_ff @(posedge clk_i) begin
    irq_q <= irq_i;
    if (rst_i) begin
      pending_q  <= '0;
      overflow_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      overflow_q <= (overflow_q & ~ovf_clr_i) | (rise & pending_q & ~grant);
      if (flush_i) begin
        pending_q <= '0;
        rr_ptr_q  <= '0;
      end else begin
        pending_q <= rise | (pending_q & ~grant);
        if (push) begin
          rr_ptr_q <= rr_ptr_d;
        end
      end
    end
  end

  assign push_o     = push;
  assign data_o     = push ? sel : '0;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule
